ex_mem_pipe: RTL and testbench
==============================

// Module: ex_mem_pipe
// PURPOSE
//  Parametrised, elastic EX->MEM pipeline register; successor to the fixed
//  32-bit always-advance EX/MEM latch. Carries the GPR write-back bundle (and optional
//  HI/LO bundle) from execute to memory with a valid/ready handshake, a
//  2-entry skid buffer so in_ready is registered, and a synchronous flush.
// PARAMETERS
//  DATA_W    32  width of write data (and HI/LO words)
//  ADDR_W    5   width of destination register address
//  NOP_ADDR  0   address driven on mem_wd when stage holds no valid bundle
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous, active-low reset
//  flush      in   1       sync: discard all held bundles this cycle
//  ex_valid   in   1       EX presents a bundle
//  ex_ready   out  1       stage can accept (registered = !skid_valid)
//  ex_wd      in   ADDR_W  destination register address
//  ex_wreg    in   1       GPR write enable
//  ex_wdata   in   DATA_W  GPR write data
//  ex_whilo   in   1       HI/LO write enable   (EX_MEM_HILO_EN only)
//  ex_hi      in   DATA_W  HI value             (EX_MEM_HILO_EN only)
//  ex_lo      in   DATA_W  LO value             (EX_MEM_HILO_EN only)
//  mem_valid  out  1       MEM-side bundle valid
//  mem_ready  in   1       MEM consumes bundle this cycle
//  mem_wd     out  ADDR_W  held address (NOP_ADDR when !mem_valid)
//  mem_wreg   out  1       held GPR write enable, gated by mem_valid
//  mem_wdata  out  DATA_W  held write data (0 when !mem_valid)
//  mem_whilo/mem_hi/mem_lo out 1/DATA_W/DATA_W  (EX_MEM_HILO_EN only)
// BEHAVIOUR
//  - Reset (rst==0, async): main_valid=0, skid_valid=0, payload regs = NOP
//    (wd=NOP_ADDR, wreg=0, wdata=0, whilo=0, hi=lo=0); ex_ready=1, mem_valid=0.
//  - accept = ex_valid & ex_ready; drain = mem_valid & mem_ready.
//  - Latency: accepted bundle appears on mem_* the next cycle when main is
//    empty or draining; throughput 1 bundle/cycle while mem_ready=1.
//  - Occupancy states: EMPTY(main=0,skid=0), ONE(main=1,skid=0), FULL(both=1).
//    EMPTY: accept -> ONE (main<=in).
//    ONE: accept&drain -> ONE (main<=in); accept&!drain -> FULL (skid<=in);
//         !accept&drain -> EMPTY; else hold.
//    FULL: ex_ready=0; drain -> ONE (main<=skid); else hold.
//  - Bundle order strictly preserved; skid never bypasses main.
//  - Payload held stable while mem_valid=1 and mem_ready=0.
//  - Flush wins over accept/drain same cycle: next state EMPTY, payload NOP,
//    input bundle offered that cycle dropped.
//  - mem_wreg/mem_whilo are AND-ed with mem_valid: no write escapes an
//    invalid slot. mem_wd=NOP_ADDR, data=0 when invalid.
//  - Reset asserted mid-transfer: all held bundles lost, outputs NOP at once.
//  - No width arithmetic; all payload fields pass through unchanged.
// CONFIGURATION
//  EX_MEM_HILO_EN defined: HI/LO ports present, carried in main and skid
//    exactly like GPR fields.
//  Undefined: HI/LO ports and registers absent; only GPR bundle carried.
// STRUCTURE
//  Shared include/package: NOP_ADDR default, ZeroWord, WriteEnable/Disable,
//  RstEnable (low), bundle field widths; packed bundle typedef (wd,wreg,
//  wdata[,whilo,hi,lo]) reused by later stage registers.
//  One sub-module: pipe_skid_buf (generic width, valid/ready 2-entry buffer,
//  flush); ex_mem_pipe packs/unpacks bundle and gates outputs.
// TESTING
//  1 Reset: rst=0 mid-run -> mem_valid=0, mem_wreg=0, mem_wd=0, ex_ready=1.
//  2 Stream: mem_ready=1, 8 bundles wd=1..8 wdata=0x100+i back-to-back ->
//    emerge 1 cycle later, in order, ex_ready never low.
//  3 Backpressure: mem_ready=0 after wd=3 accepted, send wd=4 -> FULL,
//    ex_ready=0, mem_wd=3 held; mem_ready=1 -> 3 then 4, ex_ready=1 again.
//  4 Flush in FULL with ex_valid=1 (wd=9) -> next cycle mem_valid=0,
//    mem_wd=0, wd=9 never appears.
//  5 Invalid gating: ex_valid=0, ex_wreg=1 -> mem_wreg stays 0.
//  6 EX_MEM_HILO_EN build: whilo=1 hi=0xDEAD lo=0xBEEF through stall ->
//    mem_hi/mem_lo stable until drained; absent build compiles without ports.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared widths, NOP constants and the EX/MEM bundle type; EX_MEM_HILO_EN adds HI/LO fields
package ex_mem_pipe_pkg;
  localparam int data_w_dflt = 32;
  localparam int addr_w_dflt = 5;
  localparam logic [addr_w_dflt-1:0] nop_addr_dflt = '0;
  localparam logic [data_w_dflt-1:0] zero_word = '0;
  localparam logic write_enable = 1'b1;
  localparam logic write_disable = 1'b0;
  localparam logic rst_enable = 1'b0;
  typedef struct packed {
    logic [addr_w_dflt-1:0] wd;
    logic                   wreg;
    logic [data_w_dflt-1:0] wdata;
`ifdef EX_MEM_HILO_EN
    logic                   whilo;
    logic [data_w_dflt-1:0] hi;
    logic [data_w_dflt-1:0] lo;
`endif
  } ex_mem_bundle_t;
  function automatic int bundle_w(input int data_w, input int addr_w);
`ifdef EX_MEM_HILO_EN
    return addr_w + 2 + 3 * data_w;
`else
    return addr_w + 1 + data_w;
`endif
  endfunction
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer with registered in_ready and sync flush
module pipe_skid_buf #(
  parameter int W = 8,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, accept, drain;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  assign in_ready = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data = main_q;
  // next occupancy/payload: flush empties, skid refills main on drain, input goes to skid only when main stalls
  always_comb begin
    accept = in_valid & in_ready;
    drain = main_valid_q & out_ready;
    main_valid_d = !flush & (skid_valid_q | accept | (main_valid_q & !drain));
    skid_valid_d = !flush & (skid_valid_q ? !drain : (accept & main_valid_q & !drain));
    main_d = flush ? NOP : (skid_valid_q & drain) ? skid_q : (accept & (!main_valid_q | drain)) ? in_data : main_q;
    skid_d = flush ? NOP : (accept & main_valid_q & !drain) ? in_data : skid_q;
  end
  // occupancy and payload registers, NOP on async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q <= NOP;
      skid_q <= NOP;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: elastic EX->MEM register carrying the write-back bundle (HI/LO too when EX_MEM_HILO_EN is defined)
module ex_mem_pipe import ex_mem_pipe_pkg::*; #(
  parameter int DATA_W = data_w_dflt,
  parameter int ADDR_W = addr_w_dflt,
  parameter logic [ADDR_W-1:0] NOP_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
`ifdef EX_MEM_HILO_EN
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
`endif
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata
);
  localparam int BW = bundle_w(DATA_W, ADDR_W);
  localparam logic [BW-1:0] NOP_BUNDLE = {NOP_ADDR, {(BW-ADDR_W){1'b0}}};
  logic [BW-1:0] in_data, out_data;
  logic [ADDR_W-1:0] o_wd;
  logic o_wreg;
  logic [DATA_W-1:0] o_wdata;
`ifdef EX_MEM_HILO_EN
  logic o_whilo;
  logic [DATA_W-1:0] o_hi, o_lo;
  assign in_data = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo};
  assign {o_wd, o_wreg, o_wdata, o_whilo, o_hi, o_lo} = out_data;
  // HI/LO outputs: write enable and data forced off when the slot is empty
  always_comb begin
    mem_whilo = mem_valid ? o_whilo : write_disable;
    mem_hi = mem_valid ? o_hi : '0;
    mem_lo = mem_valid ? o_lo : '0;
  end
`else
  assign in_data = {ex_wd, ex_wreg, ex_wdata};
  assign {o_wd, o_wreg, o_wdata} = out_data;
`endif
  pipe_skid_buf #(.W(BW), .NOP(NOP_BUNDLE)) u_buf (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(ex_valid), .in_ready(ex_ready), .in_data(in_data),
    .out_valid(mem_valid), .out_ready(mem_ready), .out_data(out_data)
  );
  // GPR outputs: no write or stale data escapes an invalid slot
  always_comb begin
    mem_wd = mem_valid ? o_wd : NOP_ADDR;
    mem_wreg = mem_valid ? o_wreg : write_disable;
    mem_wdata = mem_valid ? o_wdata : '0;
  end
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: randomized and directed checks of ex_mem_pipe against a depth-2 FIFO reference model
module tb_ex_mem_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 0, rst = 0, flush = 0, ex_valid = 0, ex_wreg = 0, mem_ready = 0;
  logic [AW-1:0] ex_wd = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic ex_ready, mem_valid, mem_wreg;
  logic [AW-1:0] mem_wd;
  logic [DW-1:0] mem_wdata;
`ifdef EX_MEM_HILO_EN
  logic ex_whilo = 0, mem_whilo;
  logic [DW-1:0] ex_hi = '0, ex_lo = '0, mem_hi, mem_lo;
`endif
  typedef struct packed {
    logic [AW-1:0] wd;
    logic wreg;
    logic [DW-1:0] wdata;
    logic whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } bund_t;
  bund_t q[$];
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
`ifdef EX_MEM_HILO_EN
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
`endif
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata)
  );

  function automatic bund_t cur_in();
    bund_t b = '0;
    b.wd = ex_wd;
    b.wreg = ex_wreg;
    b.wdata = ex_wdata;
`ifdef EX_MEM_HILO_EN
    b.whilo = ex_whilo;
    b.hi = ex_hi;
    b.lo = ex_lo;
`endif
    return b;
  endfunction

  function automatic logic [39:0] exp_vec();
    return (q.size() > 0) ? {q.size() < 2, 1'b1, q[0].wd, q[0].wreg, q[0].wdata}
                          : {1'b1, 1'b0, 5'd0, 1'b0, 32'd0};
  endfunction

  function automatic logic [39:0] act_vec();
    return {ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata};
  endfunction

  task automatic tick();
    bit acc, drn;
    bund_t b;
    acc = ex_valid && q.size() < 2;
    drn = q.size() > 0 && mem_ready;
    b = cur_in();
    @(posedge clk);
    if (rst) begin
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_init: got %h expected %h", act_vec(), exp_vec()); end
    rst = 1;
    mem_ready = 0; ex_valid = 1; ex_wd = 7; ex_wreg = 1; ex_wdata = $urandom;
    tick();
    tick();
    ex_valid = 0;
    vectors++;
    if (act_vec() !== exp_vec() || ex_ready !== 1'b0) begin errors++; $display("FAIL reset_prefill: got %h expected %h", act_vec(), exp_vec()); end
    #2;
    rst = 0;
    q.delete();
    #1;
    vectors++;
    if (act_vec() !== {1'b1, 1'b0, 5'd0, 1'b0, 32'd0}) begin errors++; $display("FAIL reset_midrun: got %h expected %h", act_vec(), {1'b1, 1'b0, 5'd0, 1'b0, 32'd0}); end
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic test_stream();
    mem_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      ex_valid = 1; ex_wd = i[AW-1:0]; ex_wreg = 1; ex_wdata = 32'h100 + i;
      vectors++;
      if (ex_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, ex_ready); end
      tick();
      vectors++;
      if (mem_valid !== 1'b1 || mem_wd !== i[AW-1:0] || mem_wdata !== 32'h100 + i)
        begin errors++; $display("FAIL stream_out[%0d]: got v=%b wd=%0d data=%h expected v=1 wd=%0d data=%h", i, mem_valid, mem_wd, mem_wdata, i, 32'h100 + i); end
    end
    ex_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    mem_ready = 1; ex_valid = 1; ex_wd = 3; ex_wreg = 1; ex_wdata = $urandom;
    tick();
    mem_ready = 0; ex_wd = 4; ex_wdata = $urandom;
    tick();
    ex_valid = 0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ex_ready !== 1'b0 || mem_valid !== 1'b1 || mem_wd !== 5'd3)
        begin errors++; $display("FAIL bp_full[%0d]: got rdy=%b v=%b wd=%0d expected rdy=0 v=1 wd=3", k, ex_ready, mem_valid, mem_wd); end
      tick();
    end
    mem_ready = 1;
    tick();
    vectors++;
    if (ex_ready !== 1'b1 || mem_valid !== 1'b1 || mem_wd !== 5'd4)
      begin errors++; $display("FAIL bp_second: got rdy=%b v=%b wd=%0d expected rdy=1 v=1 wd=4", ex_ready, mem_valid, mem_wd); end
    tick();
    vectors++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b expected 0", mem_valid); end
  endtask

  task automatic test_flush();
    mem_ready = 0; ex_valid = 1; ex_wreg = 1; ex_wd = 1; ex_wdata = $urandom;
    tick();
    ex_wd = 2;
    tick();
    ex_wd = 9; flush = 1;
    tick();
    flush = 0; ex_valid = 0;
    vectors++;
    if (mem_valid !== 1'b0 || mem_wd !== 5'd0 || ex_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full: got v=%b wd=%0d rdy=%b expected v=0 wd=0 rdy=1", mem_valid, mem_wd, ex_ready); end
    mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (mem_valid !== 1'b0 || mem_wd !== 5'd0) begin errors++; $display("FAIL flush_ghost[%0d]: got v=%b wd=%0d expected v=0 wd=0", k, mem_valid, mem_wd); end
    end
    mem_ready = 0; ex_valid = 1; ex_wd = 6;
    tick();
    ex_wd = 11; flush = 1;
    tick();
    flush = 0; ex_valid = 0;
    vectors++;
    if (mem_valid !== 1'b0 || mem_wd !== 5'd0) begin errors++; $display("FAIL flush_one: got v=%b wd=%0d expected v=0 wd=0", mem_valid, mem_wd); end
  endtask

  task automatic test_gating();
    ex_valid = 0; ex_wreg = 1; ex_wd = 13; ex_wdata = $urandom; mem_ready = $urandom_range(0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (mem_wreg !== 1'b0 || mem_valid !== 1'b0 || mem_wdata !== 32'd0 || mem_wd !== 5'd0)
        begin errors++; $display("FAIL gating[%0d]: got wreg=%b v=%b wd=%0d data=%h expected all zero", k, mem_wreg, mem_valid, mem_wd, mem_wdata); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ex_valid = $urandom_range(0, 1);
      mem_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      ex_wd = AW'($urandom);
      ex_wreg = $urandom_range(0, 1);
      ex_wdata = $urandom;
`ifdef EX_MEM_HILO_EN
      ex_whilo = $urandom_range(0, 1);
      ex_hi = $urandom;
      ex_lo = $urandom;
`endif
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %h expected %h", k, act_vec(), exp_vec()); end
`ifdef EX_MEM_HILO_EN
      vectors++;
      if ({mem_whilo, mem_hi, mem_lo} !== ((q.size() > 0) ? {q[0].whilo, q[0].hi, q[0].lo} : 65'd0))
        begin errors++; $display("FAIL random_hilo[%0d]: got %b/%h/%h", k, mem_whilo, mem_hi, mem_lo); end
`endif
    end
    flush = 0; ex_valid = 0; mem_ready = 1;
    tick();
    tick();
  endtask

`ifdef EX_MEM_HILO_EN
  task automatic test_hilo();
    mem_ready = 0; ex_valid = 1; ex_wd = 5; ex_whilo = 1; ex_hi = 32'hDEAD; ex_lo = 32'hBEEF;
    tick();
    ex_wd = 6; ex_hi = 32'h1234; ex_lo = 32'h5678;
    tick();
    ex_valid = 0; ex_hi = 32'hFFFF; ex_lo = 32'hEEEE;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (mem_whilo !== 1'b1 || mem_hi !== 32'hDEAD || mem_lo !== 32'hBEEF)
        begin errors++; $display("FAIL hilo_stall[%0d]: got %b/%h/%h expected 1/dead/beef", k, mem_whilo, mem_hi, mem_lo); end
      tick();
    end
    mem_ready = 1;
    tick();
    vectors++;
    if (mem_hi !== 32'h1234 || mem_lo !== 32'h5678) begin errors++; $display("FAIL hilo_second: got %h/%h expected 1234/5678", mem_hi, mem_lo); end
    tick();
    vectors++;
    if (mem_whilo !== 1'b0 || mem_hi !== 32'd0 || mem_lo !== 32'd0)
      begin errors++; $display("FAIL hilo_empty: got %b/%h/%h expected 0/0/0", mem_whilo, mem_hi, mem_lo); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_gating();
    test_random();
`ifdef EX_MEM_HILO_EN
    test_hilo();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
